// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Request/response valid-ready channels for the pipelined ALU unit.
// Revision : 1.0
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_c;
  logic             rsp_v;
  logic             rsp_z;
  logic             rsp_n;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n,
           rsp_err, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n,
           rsp_err, rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_unit
// Brief    : Two-stage handshaked 16-bit ALU (ADD/SUB/AND/OR/XOR/NOT) with flags.
// Revision : 1.0
// ============================================================================
module alu_pipe_unit #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus,
  output logic       busy
);

  localparam int         c_MSB    = WIDTH - 1;
  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_NOT = 3'd5;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_c;
  logic             r_rsp_v;
  logic             r_rsp_z;
  logic             r_rsp_n;
  logic             r_rsp_err;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_s2_adv;
  logic             w_req_fire;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  // Output register frees up whenever it is empty or being drained this cycle.
  assign w_s2_adv      = !r_rsp_valid || bus.rsp_ready;
  assign bus.req_ready = !r_s1_valid || w_s2_adv;
  assign w_req_fire    = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
    end else if (w_req_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= bus.req_op;
      r_s1_a     <= bus.req_a;
      r_s1_b     <= bus.req_b;
      r_s1_tag   <= bus.req_tag;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // The extra top bit of the difference is the unsigned borrow.
  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (r_s1_op)
      c_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) && (w_sum[c_MSB] != r_s1_a[c_MSB]);
      end
      c_OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) && (w_diff[c_MSB] != r_s1_a[c_MSB]);
      end
      c_OP_AND: w_res = r_s1_a & r_s1_b;
      c_OP_OR:  w_res = r_s1_a | r_s1_b;
      c_OP_XOR: w_res = r_s1_a ^ r_s1_b;
      c_OP_NOT: w_res = ~r_s1_b;
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_c      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (w_s2_adv) begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_result <= w_res;
        r_rsp_c      <= w_c;
        r_rsp_v      <= w_v;
        r_rsp_z      <= (w_res == '0);
        r_rsp_n      <= w_res[c_MSB];
        r_rsp_err    <= w_err;
        r_rsp_tag    <= r_s1_tag;
      end
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_v      = r_rsp_v;
  assign bus.rsp_z      = r_rsp_z;
  assign bus.rsp_n      = r_rsp_n;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_tag    = r_rsp_tag;
  assign busy           = r_s1_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_unit
// Brief    : Directed plus streaming bench for alu_pipe_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_alu_pipe_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  alu_pipe_if #(.WIDTH(16), .TAG_W(4)) bus ();

  alu_pipe_unit #(.WIDTH(16), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_count = 0;

  logic [24:0] exp_q[$];
  logic        held = 1'b0;
  logic [24:0] held_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Packed as {result, c, v, z, n, err, tag}; computed with integer arithmetic.
  function automatic logic [24:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [3:0] tag);
    int ua, ub, sa, sb, r, s;
    logic [15:0] res;
    logic c, v, err;
    ua = int'(a);  ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; err = 1'b0; res = '0;
    case (op)
      3'd0: begin r = ua + ub; res = r[15:0]; c = (r > 65535);
                  s = sa + sb; v = (s > 32767) || (s < -32768); end
      3'd1: begin r = ua - ub; res = r[15:0]; c = (ua < ub);
                  s = sa - sb; v = (s > 32767) || (s < -32768); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~b;
      default: err = 1'b1;
    endcase
    return {res, c, v, (res == 16'h0), res[15], err, tag};
  endfunction

  function automatic logic [24:0] rsp_now();
    return {bus.rsp_result, bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n, bus.rsp_err, bus.rsp_tag};
  endfunction

  // Scoreboard: sampled on the falling edge, where handshake signals are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (held) chk("rsp_stable", 64'(rsp_now()), 64'(held_val));
        if (bus.rsp_ready) begin
          rsp_count++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_unexpected: got %0h, expected no response", rsp_now());
          end else begin
            chk("rsp_vs_model", 64'(rsp_now()), 64'(exp_q.pop_front()));
          end
        end
        held     = !bus.rsp_ready;
        held_val = rsp_now();
      end else begin
        if (held) begin
          n_checks++; n_fail++;
          $display("FAIL rsp_dropped: got valid=0, expected valid=1 until accepted");
        end
        held = 1'b0;
      end
      if (bus.req_valid && bus.req_ready)
        exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_tag));
    end
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    bus.req_valid = 1'b1;
  endtask

  // Edges counted from the one that captures the request; response must show after the 2nd.
  task automatic directed(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] tag,
                          input logic [15:0] er, input logic [3:0] cvzn, input logic ee);
    int lat;
    drive(op, a, b, tag);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk(nm, 64'(rsp_now()), 64'({er, cvzn, ee, tag}));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    #12;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_fields", 64'(rsp_now()), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", 64'(bus.req_ready), 64'd1);

    directed("add_basic",  3'd0, 16'h0003, 16'h0004, 4'd5, 16'h0007, 4'b0000, 1'b0);
    directed("add_carry",  3'd0, 16'hFFFF, 16'h0001, 4'd1, 16'h0000, 4'b1010, 1'b0);
    directed("add_ovf",    3'd0, 16'h7FFF, 16'h0001, 4'd2, 16'h8000, 4'b0101, 1'b0);
    directed("sub_borrow", 3'd1, 16'h0000, 16'h0001, 4'd3, 16'hFFFF, 4'b1001, 1'b0);
    directed("sub_ovf",    3'd1, 16'h8000, 16'h0001, 4'd4, 16'h7FFF, 4'b0100, 1'b0);
    directed("and",        3'd2, 16'hF0F0, 16'hFF00, 4'd6, 16'hF000, 4'b0001, 1'b0);
    directed("or",         3'd3, 16'hF0F0, 16'hFF00, 4'd7, 16'hFFF0, 4'b0001, 1'b0);
    directed("xor",        3'd4, 16'hF0F0, 16'hFF00, 4'd8, 16'h0FF0, 4'b0000, 1'b0);
    directed("not",        3'd5, 16'h1234, 16'h00FF, 4'd9, 16'hFF00, 4'b0001, 1'b0);
    directed("illegal6",   3'd6, 16'hABCD, 16'h1234, 4'hA, 16'h0000, 4'b0010, 1'b1);
    directed("illegal7",   3'd7, 16'hFFFF, 16'hFFFF, 4'hB, 16'h0000, 4'b0010, 1'b1);

    // Backpressure: two entries fill the pipe, the third must wait.
    bus.rsp_ready = 1'b0;
    base = rsp_count;
    for (int i = 0; i < 3; i++) begin
      drive(3'(i), 16'h1000 + 16'(i), 16'h0101, 4'(i));
      @(negedge clk);
      chk("bp_req_ready", 64'(bus.req_ready), (i < 2) ? 64'd1 : 64'd0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_hold_tag", 64'(bus.rsp_tag), 64'd0);
      chk("bp_hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("bp_drain_count", 64'(rsp_count - base), 64'd3);

    // Streaming throughput with random operands, including illegal ops.
    base = rsp_count;
    for (int i = 0; i < 100; i++) begin
      drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom));
      @(negedge clk);
      chk("stream_req_ready", 64'(bus.req_ready), 64'd1);
      if (i >= 2) chk("stream_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("stream_count", 64'(rsp_count - base), 64'd100);

    // Reset with two entries in flight.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(3'd0, 16'h0010, 16'(i), 4'(10 + i));
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    base = rsp_count;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(bus.rsp_valid), 64'd0);
    end
    chk("midrst_count", 64'(rsp_count - base), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
